dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive denied dma_req cycles before the DMA port is forced to win (legal range 1..15).
REQ-002 SHALL have parameter AW, default 32, meaning address width.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports core_req / core_we  input  1 / 1  core load/store request and its write qualifier.
REQ-006 SHALL have ports core_addr / core_wdata  input  AW / 32  core address and store data.
REQ-007 SHALL have ports core_gnt / core_stall  output  1 / 1  access accepted this cycle / core must hold its pipeline.
REQ-008 SHALL have ports core_rdata / core_rvalid  output  32 / 1  core load data and its valid strobe.
REQ-009 SHALL have ports dma_req / dma_we  input  1 / 1  DMA/loader request and its write qualifier.
REQ-010 SHALL have ports dma_addr / dma_wdata  input  AW / 32  DMA address and write data.
REQ-011 SHALL have ports dma_gnt / dma_rdata / dma_rvalid  output  1 / 32 / 1  DMA grant, read data and read valid.
REQ-012 SHALL have ports mem_we / mem_addr / mem_wdata  output  1 / AW / 32  data memory write enable, address and write data.
REQ-013 SHALL have port mem_rdata  input  32  data memory combinational read data.

Function
REQ-014 SHALL grant at most one port per cycle; core_gnt and dma_gnt SHALL be combinational from the requests and registered state.
REQ-015 SHALL use default priority core over DMA when starve_cnt < STARVE_LIMIT.
REQ-016 SHALL grant DMA over core when dma_req=1 and starve_cnt == STARVE_LIMIT (forced slot).
REQ-017 SHALL increment starve_cnt, saturating at STARVE_LIMIT, each cycle dma_req=1 and dma_gnt=0.
REQ-018 SHALL clear starve_cnt on any cycle with dma_gnt=1 or dma_req=0.
REQ-019 SHALL drive the mem_addr/mem_wdata mux from the granted port; mem_we SHALL equal granted port's we, and 0 when no grant.
REQ-020 SHALL drive mem_addr/mem_wdata from the core port when nothing is granted, with mem_we=0.
REQ-021 SHALL drive core_stall = core_req & ~core_gnt, combinationally.
REQ-022 SHALL capture mem_rdata into a 32-bit read register on each granted read (we=0), with a 2-bit response-owner register set to CORE or DMA.
REQ-023 SHALL set the response owner to NONE on granted writes and idle cycles.
REQ-024 SHALL assert the owner's rvalid exactly one cycle after the read grant, for one cycle; the other rvalid SHALL remain 0.
REQ-025 SHALL drive core_rdata and dma_rdata both from the read register; it SHALL hold its value when not updated.
REQ-026 SHALL support back-to-back grants every cycle, including alternating owners, with no bubble; throughput is 1 access/cycle.
REQ-027 SHALL admit the core request on the first cycle without a forced DMA slot, when a forced DMA slot coincides with core_req; core_stall=1 during the forced slot.
REQ-028 SHALL let any request dropped before being granted vanish without side effect; there is no request queueing.

Reset
REQ-029 SHALL, while reset=1, force core_gnt=0, dma_gnt=0, mem_we=0, core_stall=0, core_rvalid=0, dma_rvalid=0.
REQ-030 SHALL, on the clock edge with reset=1, set starve_cnt=0, read register=32'h0, response owner=NONE.
REQ-031 SHALL discard a read granted in the cycle before reset assertion; no rvalid SHALL appear after reset.

Verification
REQ-032 Core only: core_req=1, core_we=0, addr=0x10, mem_rdata=0xDEADBEEF -> core_gnt=1 same cycle; core_rvalid=1, core_rdata=0xDEADBEEF next cycle.
REQ-033 Contention: core_req=1 and dma_req=1 continuously, STARVE_LIMIT=4 -> core granted 4 cycles, DMA granted 5th with core_stall=1, pattern repeats every 5 cycles.
REQ-034 DMA write alone: dma_req=1, dma_we=1, addr=0x40, wdata=0x12345678 -> dma_gnt=1, mem_we=1, mem_addr=0x40, mem_wdata=0x12345678; no rvalid next cycle.
REQ-035 Alternating reads core@0x0 then DMA@0x4 on consecutive cycles -> core_rvalid then dma_rvalid on consecutive cycles, each with its own data.
REQ-036 Reset mid-operation: starve_cnt=3, DMA read granted, reset=1 next cycle -> dma_rvalid stays 0, starve_cnt=0, all grants 0 during reset.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (core, DMA) arbiter in front of a single-ported data
// memory with combinational read data. The core normally has priority. A
// saturating starvation counter forces one DMA slot after STARVE_LIMIT
// consecutive denied DMA cycles. Load data is registered and returned one
// cycle after the grant, with a valid strobe on the port that issued the read.
module dmem_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int AW           = 32
) (
   input  logic          clk,
   input  logic          reset,
   // core port
   input  logic          core_req,
   input  logic          core_we,
   input  logic [AW-1:0] core_addr,
   input  logic [31:0]   core_wdata,
   output logic          core_gnt,
   output logic          core_stall,
   output logic [31:0]   core_rdata,
   output logic          core_rvalid,
   // DMA / loader port
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [31:0]   dma_wdata,
   output logic          dma_gnt,
   output logic [31:0]   dma_rdata,
   output logic          dma_rvalid,
   // data memory
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata
);

   // Response owner encoding for the registered read data.
   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_CORE = 2'd1;
   localparam logic [1:0] OWN_DMA  = 2'd2;

   // Starvation threshold; the counter is 4 bits wide, enough for 1..15.
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0]  starve_cnt_reg;
   logic [3:0]  starve_cnt_next;
   logic [31:0] rdata_reg;
   logic [31:0] rdata_next;
   logic [1:0]  owner_reg;
   logic [1:0]  owner_next;

   logic        forced_slot;
   logic        core_win;
   logic        dma_win;

   // Grant decision: core first, unless the DMA has been starved long enough.
   // Once the forced slot is consumed the counter clears, so the core wins the
   // very next cycle.
   always_comb begin
      forced_slot = dma_req && (starve_cnt_reg == LIMIT);
      core_win    = !reset && core_req && !forced_slot;
      dma_win     = !reset && dma_req && !core_win;
   end

   assign core_gnt   = core_win;
   assign dma_gnt    = dma_win;
   assign core_stall = !reset && core_req && !core_win;

   // Memory-side mux: the DMA drives the bus only when granted; otherwise the
   // core fields pass through and the write enable stays low unless granted.
   always_comb begin
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
      mem_we    = 1'b0;
      if (dma_win) begin
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
         mem_we    = dma_we;
      end else if (core_win) begin
         mem_we    = core_we;
      end
   end

   // Starvation counter: count denied DMA cycles (saturating), clear on a DMA
   // grant or when the DMA withdraws its request.
   always_comb begin
      starve_cnt_next = 4'd0;
      if (dma_req && !dma_win) begin
         if (starve_cnt_reg == LIMIT) begin
            starve_cnt_next = starve_cnt_reg;
         end else begin
            starve_cnt_next = starve_cnt_reg + 4'd1;
         end
      end
   end

   // Read capture: latch memory data and its owner on a granted read; writes
   // and idle cycles leave the data untouched but retire the owner.
   always_comb begin
      rdata_next = rdata_reg;
      owner_next = OWN_NONE;
      if (core_win && !core_we) begin
         rdata_next = mem_rdata;
         owner_next = OWN_CORE;
      end else if (dma_win && !dma_we) begin
         rdata_next = mem_rdata;
         owner_next = OWN_DMA;
      end
   end

   // State registers; reset also drops any read response still in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt_reg <= 4'd0;
         rdata_reg      <= 32'h0;
         owner_reg      <= OWN_NONE;
      end else begin
         starve_cnt_reg <= starve_cnt_next;
         rdata_reg      <= rdata_next;
         owner_reg      <= owner_next;
      end
   end

   assign core_rdata  = rdata_reg;
   assign dma_rdata   = rdata_reg;
   assign core_rvalid = !reset && (owner_reg == OWN_CORE);
   assign dma_rvalid  = !reset && (owner_reg == OWN_DMA);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed, table-driven bench for dmem_arbiter (STARVE_LIMIT=4, AW=32).
// Each record holds one cycle of inputs plus the outputs expected in that
// cycle; registered outputs reflect what the previous record caused.
module tb_dmem_arbiter;

   typedef struct {
      logic        rst;
      logic        creq, cwe;
      logic [31:0] caddr, cwd;
      logic        dreq, dwe;
      logic [31:0] daddr, dwd;
      logic [31:0] mrd;
      logic        e_cg, e_dg, e_st, e_mwe;
      logic [31:0] e_maddr, e_mwd;
      logic        e_crv, e_drv;
      logic [31:0] e_rd;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        core_req = 1'b0, core_we = 1'b0;
   logic [31:0] core_addr = 32'h0, core_wdata = 32'h0;
   logic        dma_req = 1'b0, dma_we = 1'b0;
   logic [31:0] dma_addr = 32'h0, dma_wdata = 32'h0;
   logic [31:0] mem_rdata = 32'h0;
   logic        core_gnt, core_stall, core_rvalid;
   logic [31:0] core_rdata;
   logic        dma_gnt, dma_rvalid;
   logic [31:0] dma_rdata;
   logic        mem_we;
   logic [31:0] mem_addr, mem_wdata;

   int nvec = 0;
   int nerr = 0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   dmem_arbiter #(.STARVE_LIMIT(4), .AW(32)) dut (
      .clk(clk), .reset(reset),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_gnt(core_gnt), .core_stall(core_stall),
      .core_rdata(core_rdata), .core_rvalid(core_rvalid),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
      .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
      .dma_rvalid(dma_rvalid),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   function automatic vec_t mk(
      input logic rst, input logic creq, input logic cwe,
      input logic [31:0] caddr, input logic [31:0] cwd,
      input logic dreq, input logic dwe,
      input logic [31:0] daddr, input logic [31:0] dwd, input logic [31:0] mrd,
      input logic cg, input logic dg, input logic st, input logic mwe,
      input logic [31:0] maddr, input logic [31:0] mwd,
      input logic crv, input logic drv, input logic [31:0] rd);
      vec_t v;
      v.rst = rst; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
      v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd; v.mrd = mrd;
      v.e_cg = cg; v.e_dg = dg; v.e_st = st; v.e_mwe = mwe;
      v.e_maddr = maddr; v.e_mwd = mwd;
      v.e_crv = crv; v.e_drv = drv; v.e_rd = rd;
      return v;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         nerr++;
         $display("FAIL vec %0d %s: got %h, expected %h", nvec, name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      @(posedge clk);
      #1;
      reset = v.rst;
      core_req = v.creq; core_we = v.cwe; core_addr = v.caddr; core_wdata = v.cwd;
      dma_req = v.dreq; dma_we = v.dwe; dma_addr = v.daddr; dma_wdata = v.dwd;
      mem_rdata = v.mrd;
      @(negedge clk);
      cmp("core_gnt",    {31'h0, core_gnt},    {31'h0, v.e_cg});
      cmp("dma_gnt",     {31'h0, dma_gnt},     {31'h0, v.e_dg});
      cmp("core_stall",  {31'h0, core_stall},  {31'h0, v.e_st});
      cmp("mem_we",      {31'h0, mem_we},      {31'h0, v.e_mwe});
      cmp("mem_addr",    mem_addr,             v.e_maddr);
      cmp("mem_wdata",   mem_wdata,            v.e_mwd);
      cmp("core_rvalid", {31'h0, core_rvalid}, {31'h0, v.e_crv});
      cmp("dma_rvalid",  {31'h0, dma_rvalid},  {31'h0, v.e_drv});
      cmp("core_rdata",  core_rdata,           v.e_rd);
      cmp("dma_rdata",   dma_rdata,            v.e_rd);
      $display("vec %0d: rst=%0b creq=%0b dreq=%0b -> cg=%0b dg=%0b st=%0b we=%0b addr=%h crv=%0b drv=%0b rd=%h",
               nvec, v.rst, v.creq, v.dreq, core_gnt, dma_gnt, core_stall,
               mem_we, mem_addr, core_rvalid, dma_rvalid, core_rdata);
      nvec++;
   endtask

   // Both ports reading: core at 0x100/0x300, DMA at 0x200/0x400.
   function automatic vec_t both(input logic [31:0] ca, input logic [31:0] da,
                                 input logic [31:0] mrd, input logic dma_wins,
                                 input logic crv, input logic drv, input logic [31:0] rd);
      return mk(0, 1, 0, ca, 0, 1, 0, da, 0, mrd,
                !dma_wins, dma_wins, dma_wins, 0, dma_wins ? da : ca, 0, crv, drv, rd);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Directed table
      tbl.push_back(mk(1, 1, 0, 32'h10, 0, 1, 0, 32'h0, 0, 32'hAAAA0000,  0, 0, 0, 0, 32'h10, 0,  0, 0, 32'h0));
      // core read 0x10, memory returns DEADBEEF
      tbl.push_back(mk(0, 1, 0, 32'h10, 0, 0, 0, 32'h0, 0, 32'hDEADBEEF,  1, 0, 0, 0, 32'h10, 0,  0, 0, 32'h0));
      tbl.push_back(mk(0, 0, 0, 32'h8, 32'h5, 0, 0, 32'h0, 0, 32'h11111111, 0, 0, 0, 0, 32'h8, 32'h5, 1, 0, 32'hDEADBEEF));
      // DMA write alone
      tbl.push_back(mk(0, 0, 0, 32'h99, 0, 1, 1, 32'h40, 32'h12345678, 32'h22222222,
                       0, 1, 0, 1, 32'h40, 32'h12345678, 0, 0, 32'hDEADBEEF));
      tbl.push_back(mk(0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h33333333,   0, 0, 0, 0, 32'h0, 0,  0, 0, 32'hDEADBEEF));
      // alternating core@0 then DMA@4
      tbl.push_back(mk(0, 1, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'hC0C0C0C0,   1, 0, 0, 0, 32'h0, 0,  0, 0, 32'hDEADBEEF));
      tbl.push_back(mk(0, 0, 0, 32'h0, 0, 1, 0, 32'h4, 0, 32'hD4D4D4D4,   0, 1, 0, 0, 32'h4, 0,  1, 0, 32'hC0C0C0C0));
      tbl.push_back(mk(0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h44444444,   0, 0, 0, 0, 32'h0, 0,  0, 1, 32'hD4D4D4D4));
      // core write, then idle: read register must hold
      tbl.push_back(mk(0, 1, 1, 32'h20, 32'hCAFEF00D, 0, 0, 32'h0, 0, 32'h55555555,
                       1, 0, 0, 1, 32'h20, 32'hCAFEF00D, 0, 0, 32'hD4D4D4D4));
      tbl.push_back(mk(0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h66666666,   0, 0, 0, 0, 32'h0, 0,  0, 0, 32'hD4D4D4D4));
      // continuous contention: DMA wins every 5th cycle (slots 4 and 9)
      for (int i = 0; i <= 10; i++) begin
         tbl.push_back(both(32'h100, 32'h200, 32'h10 + i, (i % 5) == 4,
                            (i > 0) && ((i - 1) % 5 != 4),
                            (i > 0) && ((i - 1) % 5 == 4),
                            (i == 0) ? 32'hD4D4D4D4 : 32'h10 + i - 1));
      end
      tbl.push_back(mk(0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0,          0, 0, 0, 0, 32'h0, 0,  1, 0, 32'h1A));

      repeat (2) @(posedge clk);
      foreach (tbl[i]) apply(tbl[i]);

      // Reset in the cycle after a granted DMA read: no response may surface,
      // and the starvation count restarts from zero.
      apply(both(32'h300, 32'h400, 32'h51, 0, 0, 0, 32'h1A));
      apply(both(32'h300, 32'h400, 32'h52, 0, 1, 0, 32'h51));
      apply(both(32'h300, 32'h400, 32'h53, 0, 1, 0, 32'h52));
      apply(mk(0, 0, 0, 32'h300, 0, 1, 0, 32'h400, 0, 32'h54,  0, 1, 0, 0, 32'h400, 0,  1, 0, 32'h53));
      apply(mk(1, 1, 0, 32'h300, 0, 1, 0, 32'h400, 0, 32'h55,  0, 0, 0, 0, 32'h300, 0,  0, 0, 32'h54));
      apply(both(32'h300, 32'h400, 32'h60, 0, 0, 0, 32'h0));
      apply(both(32'h300, 32'h400, 32'h61, 0, 1, 0, 32'h60));
      apply(both(32'h300, 32'h400, 32'h62, 0, 1, 0, 32'h61));
      apply(both(32'h300, 32'h400, 32'h63, 0, 1, 0, 32'h62));
      apply(both(32'h300, 32'h400, 32'h64, 1, 1, 0, 32'h63));

      // DMA dropping its request clears the count; the forced slot carries
      // the DMA write qualifier and data onto the memory bus.
      apply(both(32'h300, 32'h400, 32'h70, 0, 0, 1, 32'h64));
      apply(both(32'h300, 32'h400, 32'h71, 0, 1, 0, 32'h70));
      apply(both(32'h300, 32'h400, 32'h72, 0, 1, 0, 32'h71));
      apply(mk(0, 1, 0, 32'h300, 0, 0, 0, 32'h400, 0, 32'h73,  1, 0, 0, 0, 32'h300, 0,  1, 0, 32'h72));
      apply(both(32'h300, 32'h400, 32'h74, 0, 1, 0, 32'h73));
      apply(both(32'h300, 32'h400, 32'h75, 0, 1, 0, 32'h74));
      apply(both(32'h300, 32'h400, 32'h76, 0, 1, 0, 32'h75));
      apply(both(32'h300, 32'h400, 32'h77, 0, 1, 0, 32'h76));
      apply(mk(0, 1, 0, 32'h300, 0, 1, 1, 32'h400, 32'hBEEF0001, 32'h78,
               0, 1, 1, 1, 32'h400, 32'hBEEF0001, 1, 0, 32'h77));
      apply(mk(0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h79,      0, 0, 0, 0, 32'h0, 0,  0, 0, 32'h77));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
